// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared types, opcode enum, access-size encoding and load/store funct3 codes.
// Rev 1.0
`default_nettype none

package memory_stage_pkg;

   typedef logic [63:0] u64;
   typedef logic [31:0] u32;
   typedef logic [7:0]  u8;
   typedef logic [4:0]  u5;

   typedef logic [1:0] msize_t;

   localparam msize_t MSIZE_B = 2'd0;
   localparam msize_t MSIZE_H = 2'd1;
   localparam msize_t MSIZE_W = 2'd2;
   localparam msize_t MSIZE_D = 2'd3;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011
   } opc_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SD  = 3'b011;

   function automatic logic is_misaligned(input logic [2:0] addr_lo, input msize_t size);
      case (size)
         MSIZE_B: is_misaligned = 1'b0;
         MSIZE_H: is_misaligned = addr_lo[0];
         MSIZE_W: is_misaligned = |addr_lo[1:0];
         default: is_misaligned = |addr_lo;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/memory_stage_if.sv
// memory_stage_if: data-bus request/response bundle between the memory stage and the data memory.
// Rev 1.0
`default_nettype none

interface memory_stage_if;
   import memory_stage_pkg::*;

   logic   dreq_valid;
   u64     dreq_addr;
   msize_t dreq_size;
   u8      dreq_strobe;
   u64     dreq_data;
   logic   dresp_data_ok;
   u64     dresp_data;

   modport master (
      output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  dresp_data_ok, dresp_data
   );

   modport slave (
      input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output dresp_data_ok, dresp_data
   );

endinterface

`default_nettype wire

// File: rtl/memory_stage_mem_align.sv
// mem_align: byte-lane shifting, store strobe generation and load sign/zero extension.
// Rev 1.0
`default_nettype none

module mem_align
   import memory_stage_pkg::*;
(
   input  logic [2:0] i_offset,
   input  msize_t     i_size,
   input  logic       i_unsigned,
   input  logic       i_store,
   input  u64         i_wdata,
   input  u64         i_rdata,
   output u8          o_strobe,
   output u64         o_wdata,
   output u64         o_rdata
);

   u8  w_mask;
   u64 w_raw;

   always_comb begin
      case (i_size)
         MSIZE_B: w_mask = 8'h01;
         MSIZE_H: w_mask = 8'h03;
         MSIZE_W: w_mask = 8'h0F;
         default: w_mask = 8'hFF;
      endcase

      // Lanes shifted past byte 7 are dropped, matching a single doubleword beat.
      o_strobe = i_store ? u8'(w_mask << i_offset) : 8'h00;
      o_wdata  = i_wdata << {i_offset, 3'b000};
      w_raw    = i_rdata >> {i_offset, 3'b000};

      case (i_size)
         MSIZE_B: o_rdata = i_unsigned ? {56'd0, w_raw[7:0]}  : {{56{w_raw[7]}},  w_raw[7:0]};
         MSIZE_H: o_rdata = i_unsigned ? {48'd0, w_raw[15:0]} : {{48{w_raw[15]}}, w_raw[15:0]};
         MSIZE_W: o_rdata = i_unsigned ? {32'd0, w_raw[31:0]} : {{32{w_raw[31]}}, w_raw[31:0]};
         default: o_rdata = w_raw;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
// memory_stage: IDLE/WAIT load-store stage between execute and writeback.
// Optional MEM_MISALIGN_CHECK_EN traps misaligned accesses instead of issuing them. Rev 1.0
`default_nettype none

module memory_stage
   import memory_stage_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   execute_valid,
   input  u64     reg_execute_ALU_data_out,
   input  u64     reg_execute_rs2_data,
   input  u64     reg_execute_pc,
   input  u32     reg_execute_ins,
   input  u5      reg_execute_rd,
   input  logic   reg_execute_reg_w,
   input  logic   reg_execute_mem_r,
   input  logic   reg_execute_mem_w,
   output logic   memory_busy,
   memory_stage_if.master dbus,
   output logic   memory_valid,
   output u64     reg_memory_ALU_data_out,
   output u64     reg_memory_data_out,
   output u64     reg_memory_pc,
   output u32     reg_memory_ins,
   output u5      reg_memory_rd,
   output logic   reg_memory_reg_w,
   output logic   reg_memory_mem_r,
   output logic   mem_misalign
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t r_state;
   u64     r_rs2;
   logic   r_mem_w;
   logic   r_reg_w_pend;
   logic   r_dreq_valid;
   logic   r_mem_misalign;

   msize_t w_size;
   u8      w_strobe;
   u64     w_wdata;
   u64     w_load_data;
   logic   w_mem_op;
   logic   w_misalign;

   assign w_mem_op = reg_execute_mem_r | reg_execute_mem_w;
   assign w_size   = msize_t'(reg_memory_ins[13:12]);

`ifdef MEM_MISALIGN_CHECK_EN
   assign w_misalign = w_mem_op &&
                       is_misaligned(reg_execute_ALU_data_out[2:0], msize_t'(reg_execute_ins[13:12]));
`else
   assign w_misalign = 1'b0;
`endif

   mem_align u_mem_align (
      .i_offset   (reg_memory_ALU_data_out[2:0]),
      .i_size     (w_size),
      .i_unsigned (reg_memory_ins[14]),
      .i_store    (r_mem_w),
      .i_wdata    (r_rs2),
      .i_rdata    (dbus.dresp_data),
      .o_strobe   (w_strobe),
      .o_wdata    (w_wdata),
      .o_rdata    (w_load_data)
   );

   // Request fields come straight from the latched instruction, so they hold for the whole WAIT.
   assign dbus.dreq_valid  = r_dreq_valid;
   assign dbus.dreq_addr   = reg_memory_ALU_data_out;
   assign dbus.dreq_size   = w_size;
   assign dbus.dreq_strobe = w_strobe;
   assign dbus.dreq_data   = w_wdata;

   assign memory_busy  = (r_state != S_IDLE);
   assign mem_misalign = r_mem_misalign;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state                 <= S_IDLE;
         r_rs2                   <= '0;
         r_mem_w                 <= 1'b0;
         r_reg_w_pend            <= 1'b0;
         r_dreq_valid            <= 1'b0;
         r_mem_misalign          <= 1'b0;
         memory_valid            <= 1'b0;
         reg_memory_ALU_data_out <= '0;
         reg_memory_data_out     <= '0;
         reg_memory_pc           <= '0;
         reg_memory_ins          <= '0;
         reg_memory_rd           <= '0;
         reg_memory_reg_w        <= 1'b0;
         reg_memory_mem_r        <= 1'b0;
      end else begin
         memory_valid     <= 1'b0;
         reg_memory_reg_w <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (execute_valid) begin
                  reg_memory_ALU_data_out <= reg_execute_ALU_data_out;
                  reg_memory_pc           <= reg_execute_pc;
                  reg_memory_ins          <= reg_execute_ins;
                  reg_memory_rd           <= reg_execute_rd;
                  reg_memory_mem_r        <= reg_execute_mem_r;
                  reg_memory_data_out     <= '0;
                  r_rs2                   <= reg_execute_rs2_data;
                  r_mem_w                 <= reg_execute_mem_w;
                  r_reg_w_pend            <= reg_execute_reg_w;
                  r_mem_misalign          <= w_misalign;
                  if (w_misalign) begin
                     memory_valid <= 1'b1;
                  end else if (w_mem_op) begin
                     r_state      <= S_WAIT;
                     r_dreq_valid <= 1'b1;
                  end else begin
                     memory_valid     <= 1'b1;
                     reg_memory_reg_w <= reg_execute_reg_w;
                  end
               end
            end
            S_WAIT: begin
               if (dbus.dresp_data_ok) begin
                  r_state             <= S_IDLE;
                  r_dreq_valid        <= 1'b0;
                  memory_valid        <= 1'b1;
                  reg_memory_reg_w    <= r_reg_w_pend;
                  reg_memory_data_out <= reg_memory_mem_r ? w_load_data : 64'd0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage; build with MEM_MISALIGN_CHECK_EN to cover the trap path.
// Rev 1.0
`default_nettype none

module tb_memory_stage;
   import memory_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic execute_valid;
   u64   reg_execute_ALU_data_out, reg_execute_rs2_data, reg_execute_pc;
   u32   reg_execute_ins;
   u5    reg_execute_rd;
   logic reg_execute_reg_w, reg_execute_mem_r, reg_execute_mem_w;
   logic memory_busy, memory_valid;
   u64   reg_memory_ALU_data_out, reg_memory_data_out, reg_memory_pc;
   u32   reg_memory_ins;
   u5    reg_memory_rd;
   logic reg_memory_reg_w, reg_memory_mem_r, mem_misalign;

   memory_stage_if dbus ();

   memory_stage dut (
      .clk                      (clk),
      .rst                      (rst),
      .execute_valid            (execute_valid),
      .reg_execute_ALU_data_out (reg_execute_ALU_data_out),
      .reg_execute_rs2_data     (reg_execute_rs2_data),
      .reg_execute_pc           (reg_execute_pc),
      .reg_execute_ins          (reg_execute_ins),
      .reg_execute_rd           (reg_execute_rd),
      .reg_execute_reg_w        (reg_execute_reg_w),
      .reg_execute_mem_r        (reg_execute_mem_r),
      .reg_execute_mem_w        (reg_execute_mem_w),
      .memory_busy              (memory_busy),
      .dbus                     (dbus),
      .memory_valid             (memory_valid),
      .reg_memory_ALU_data_out  (reg_memory_ALU_data_out),
      .reg_memory_data_out      (reg_memory_data_out),
      .reg_memory_pc            (reg_memory_pc),
      .reg_memory_ins           (reg_memory_ins),
      .reg_memory_rd            (reg_memory_rd),
      .reg_memory_reg_w         (reg_memory_reg_w),
      .reg_memory_mem_r         (reg_memory_mem_r),
      .mem_misalign             (mem_misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      u64   alu;
      u64   data;
      u64   pc;
      u32   ins;
      u5    rd;
      logic reg_w;
      logic mem_r;
      logic mis;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic prev_valid = 1'b0;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (prev_valid) begin
            check_value("post_valid_low", {63'd0, memory_valid}, 64'd0);
            check_value("post_reg_w_low", {63'd0, reg_memory_reg_w}, 64'd0);
         end
         if (memory_valid) begin
            if (sb_q.size() == 0) begin
               check_value("unexpected_valid", {63'd0, memory_valid}, 64'd0);
            end else begin
               e = sb_q.pop_front();
               check_value("alu",      reg_memory_ALU_data_out, e.alu);
               check_value("data",     reg_memory_data_out, e.data);
               check_value("pc",       reg_memory_pc, e.pc);
               check_value("ins",      {32'd0, reg_memory_ins}, {32'd0, e.ins});
               check_value("rd",       {59'd0, reg_memory_rd}, {59'd0, e.rd});
               check_value("reg_w",    {63'd0, reg_memory_reg_w}, {63'd0, e.reg_w});
               check_value("mem_r",    {63'd0, reg_memory_mem_r}, {63'd0, e.mem_r});
               check_value("misalign", {63'd0, mem_misalign}, {63'd0, e.mis});
            end
         end
      end
      prev_valid = memory_valid & ~rst;
   end

   task automatic issue(input u64 alu, input u64 rs2, input u64 pc, input u32 ins, input u5 rd,
                        input logic reg_w, input logic mem_r, input logic mem_w,
                        input u64 exp_data, input logic exp_mis, input logic push);
      exp_t x;
      int n = 0;
      @(negedge clk);
      @(negedge clk);
      while (memory_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (memory_busy) check_value("busy_timeout", {63'd0, memory_busy}, 64'd0);
      reg_execute_ALU_data_out = alu;
      reg_execute_rs2_data     = rs2;
      reg_execute_pc           = pc;
      reg_execute_ins          = ins;
      reg_execute_rd           = rd;
      reg_execute_reg_w        = reg_w;
      reg_execute_mem_r        = mem_r;
      reg_execute_mem_w        = mem_w;
      execute_valid            = 1'b1;
      if (push) begin
         x.alu = alu; x.data = exp_data; x.pc = pc; x.ins = ins; x.rd = rd;
         x.reg_w = exp_mis ? 1'b0 : reg_w; x.mem_r = mem_r; x.mis = exp_mis;
         sb_q.push_back(x);
      end
      @(negedge clk);
      execute_valid = 1'b0;
   endtask

   // Memory responder: dresp_data_ok is raised after lat extra cycles of dreq_valid.
   task automatic serve(input int lat, input u64 rdata, input u64 exp_addr, input logic [1:0] exp_size,
                        input u8 exp_strobe, input u64 exp_wdata, input logic chk_wdata, input logic poke);
      int n = 0;
      int hi;
      while (!dbus.dreq_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!dbus.dreq_valid) begin
         check_value("dreq_timeout", {63'd0, dbus.dreq_valid}, 64'd1);
         return;
      end
      hi = 1;
      check_value("dreq_addr",   dbus.dreq_addr, exp_addr);
      check_value("dreq_size",   {62'd0, dbus.dreq_size}, {62'd0, exp_size});
      check_value("dreq_strobe", {56'd0, dbus.dreq_strobe}, {56'd0, exp_strobe});
      if (chk_wdata) check_value("dreq_data", dbus.dreq_data, exp_wdata);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         if (poke && i == 0) begin
            reg_execute_ALU_data_out = 64'hDEAD;
            reg_execute_mem_r = 1'b0;
            reg_execute_mem_w = 1'b0;
            reg_execute_reg_w = 1'b1;
            execute_valid = 1'b1;
         end
         if (poke && i == 1) execute_valid = 1'b0;
         if (dbus.dreq_valid) hi++;
      end
      check_value("dreq_addr_hold", dbus.dreq_addr, exp_addr);
      dbus.dresp_data_ok = 1'b1;
      dbus.dresp_data    = rdata;
      @(negedge clk);
      dbus.dresp_data_ok = 1'b0;
      dbus.dresp_data    = {$urandom, $urandom};
      check_value("dreq_drop", {63'd0, dbus.dreq_valid}, 64'd0);
      check_value("dreq_hold_cycles", 64'(hi), 64'(lat + 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      execute_valid = 1'b0;
      reg_execute_ALU_data_out = '0; reg_execute_rs2_data = '0; reg_execute_pc = '0;
      reg_execute_ins = '0; reg_execute_rd = '0;
      reg_execute_reg_w = 1'b0; reg_execute_mem_r = 1'b0; reg_execute_mem_w = 1'b0;
      dbus.dresp_data_ok = 1'b0;
      dbus.dresp_data    = '0;
      repeat (3) @(negedge clk);
      check_value("rst_valid",    {63'd0, memory_valid}, 64'd0);
      check_value("rst_dreq",     {63'd0, dbus.dreq_valid}, 64'd0);
      check_value("rst_busy",     {63'd0, memory_busy}, 64'd0);
      check_value("rst_reg_w",    {63'd0, reg_memory_reg_w}, 64'd0);
      check_value("rst_mem_r",    {63'd0, reg_memory_mem_r}, 64'd0);
      check_value("rst_misalign", {63'd0, mem_misalign}, 64'd0);
      check_value("rst_alu",      reg_memory_ALU_data_out, 64'd0);
      check_value("rst_data",     reg_memory_data_out, 64'd0);
      check_value("rst_addr",     dbus.dreq_addr, 64'd0);
      check_value("rst_wdata",    dbus.dreq_data, 64'd0);
      rst = 1'b0;

      // ALU pass-through
      issue(64'h1234, 64'h0, 64'h100, 32'h0000_0093, 5'd1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
      // LB, negative byte, three wait cycles
      issue(64'h1003, 64'h0, 64'h104, 32'h0000_0283, 5'd5, 1'b1, 1'b1, 1'b0,
            64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b1);
      serve(3, 64'h0000_0000_8000_0000, 64'h1003, 2'd0, 8'h00, 64'd0, 1'b0, 1'b0);
      // SH in the top lanes
      issue(64'h2006, 64'hABCD, 64'h108, 32'h0000_1023, 5'd0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b0, 1'b1);
      serve(1, 64'h0, 64'h2006, 2'd1, 8'hC0, 64'hABCD_0000_0000_0000, 1'b1, 1'b0);
      // LWU, zero extension, immediate response
      issue(64'h4, 64'h0, 64'h10C, 32'h0000_6303, 5'd6, 1'b1, 1'b1, 1'b0,
            64'h0000_0000_F000_0000, 1'b0, 1'b1);
      serve(0, 64'hF000_0000_0000_0000, 64'h4, 2'd2, 8'h00, 64'd0, 1'b0, 1'b0);
      // SD full doubleword
      issue(64'h3000, 64'h1122_3344_5566_7788, 64'h110, 32'h0000_3023, 5'd0, 1'b0, 1'b0, 1'b1,
            64'd0, 1'b0, 1'b1);
      serve(2, 64'h0, 64'h3000, 2'd3, 8'hFF, 64'h1122_3344_5566_7788, 1'b1, 1'b0);
      // LH negative halfword
      issue(64'h1002, 64'h0, 64'h114, 32'h0000_1383, 5'd7, 1'b1, 1'b1, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
      serve(1, 64'h0000_0000_FFFE_0000, 64'h1002, 2'd1, 8'h00, 64'd0, 1'b0, 1'b0);
      // SB in lane 7: upper rs2 bits fall off
      issue(64'h2007, 64'h1234_5678_9ABC_DE5A, 64'h118, 32'h0000_0023, 5'd0, 1'b0, 1'b0, 1'b1,
            64'd0, 1'b0, 1'b1);
      serve(1, 64'h0, 64'h2007, 2'd0, 8'h80, 64'h5A00_0000_0000_0000, 1'b1, 1'b0);
      // LD with an execute_valid pulse during WAIT that must be ignored
      issue(64'h3008, 64'h0, 64'h11C, 32'h0000_3403, 5'd8, 1'b1, 1'b1, 1'b0,
            64'h8877_6655_4433_2211, 1'b0, 1'b1);
      serve(4, 64'h8877_6655_4433_2211, 64'h3008, 2'd3, 8'h00, 64'd0, 1'b0, 1'b1);
      // LHU zero extension
      issue(64'h6, 64'h0, 64'h120, 32'h0000_5503, 5'd10, 1'b1, 1'b1, 1'b0, 64'h8001, 1'b0, 1'b1);
      serve(1, 64'h8001_0000_0000_0000, 64'h6, 2'd1, 8'h00, 64'd0, 1'b0, 1'b0);

      // Reset while waiting abandons the access; the late response is ignored
      issue(64'h10, 64'h0, 64'h124, 32'h0000_2303, 5'd6, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
      check_value("abort_dreq_up", {63'd0, dbus.dreq_valid}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_value("abort_dreq",  {63'd0, dbus.dreq_valid}, 64'd0);
      check_value("abort_busy",  {63'd0, memory_busy}, 64'd0);
      dbus.dresp_data_ok = 1'b1;
      dbus.dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      dbus.dresp_data_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_value("abort_no_valid", {63'd0, memory_valid}, 64'd0);
         check_value("abort_no_dreq",  {63'd0, dbus.dreq_valid}, 64'd0);
         @(negedge clk);
      end

      // Recovery after the abort
      issue(64'h55AA, 64'h0, 64'h128, 32'h0000_0093, 5'd1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

`ifdef MEM_MISALIGN_CHECK_EN
      issue(64'h2, 64'h0, 64'h12C, 32'h0000_2483, 5'd9, 1'b1, 1'b1, 1'b0, 64'd0, 1'b1, 1'b1);
      check_value("mis_no_dreq", {63'd0, dbus.dreq_valid}, 64'd0);
      @(negedge clk);
      check_value("mis_no_dreq2", {63'd0, dbus.dreq_valid}, 64'd0);
      check_value("mis_idle", {63'd0, memory_busy}, 64'd0);
`else
      issue(64'h2, 64'h0, 64'h12C, 32'h0000_2483, 5'd9, 1'b1, 1'b1, 1'b0,
            64'hFFFF_FFFF_89AB_CDEF, 1'b0, 1'b1);
      serve(1, 64'h0000_89AB_CDEF_0000, 64'h2, 2'd2, 8'h00, 64'd0, 1'b0, 1'b0);
`endif

      repeat (5) @(negedge clk);
      check_value("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
